piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time on sdo, framed by sframe.
- Forms the transmit end of the team's byte-register datapath. The receiving side is a serial-to-parallel shift register feeding an enable-loaded holding register.
- The global en input stalls the whole block, with the same meaning as the load enable on the holding registers.

Parameters:
- WIDTH, 8: word width in bits; must be ≥2.
- DIV, 4: clock cycles per serial bit; must be ≥1.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset; low at a rising edge of clk resets the block.
- en  input  1  enable; when low, all internal state and registered outputs hold.
- d  input  WIDTH  parallel word to transmit.
- d_valid  input  1  d holds a word to send.
- d_ready  output  1  block can accept a word this cycle; combinational, equal to reset & en & (state==IDLE).
- sdo  output  1  serial data out, registered.
- sframe  output  1  high while a word is being shifted out, registered.
- done  output  1  one-enabled-cycle pulse after the last bit period, registered.

Behaviour:
- Reset:
  - Synchronous, and takes priority over en.
  - state=IDLE, shift register=0, bit counter=0, div counter=0.
  - sdo=0, sframe=0, done=0.
  - d_ready=0 while reset is low.
- States:
  - IDLE: sframe=0, sdo=0.
  - SHIFT: sframe=1.
- Accept: a word is taken when d_valid & d_ready are both high at a rising edge (cycle t).
  - At that edge, d loads into the shift register and the block enters SHIFT with both counters at 0.
  - If the handshake does not occur, d and d_valid are ignored.
- Bit timing, for accept at edge t with en held high:
  - Bit k (k=0..WIDTH-1, in MSB_FIRST order) is driven on sdo during cycles t+1+k*DIV through t+(k+1)*DIV.
  - sframe is high during cycles t+1 through t+WIDTH*DIV.
- Counters:
  - The div counter runs 0..DIV-1.
  - On wrap, the shift register shifts and the bit counter increments.
  - When the bit counter wraps at WIDTH-1 together with a div-counter wrap, the block returns to IDLE.
- End of word:
  - In cycle t+1+WIDTH*DIV: state=IDLE, sframe=0, sdo=0, done=1, d_ready=1 (if en).
  - A new word may be accepted in that same cycle (back-to-back).
  - Minimum word period is WIDTH*DIV+1 cycles.
  - done clears at the next enabled edge.
- During SHIFT:
  - d_ready=0.
  - d_valid and changes on d are ignored; the loaded word is not affected.
- en low:
  - All registers, including sdo, sframe, done and both counters, hold their values.
  - d_ready=0.
  - The stall stretches the current bit period by the number of stalled cycles.
  - A done pulse that coincides with a stall stays high until the first enabled edge after the stall.
- Reset mid-word: the word is abandoned and no done pulse is produced. The first IDLE cycle after reset releases shows d_ready=1 (if en).
- DIV=1: each bit lasts one cycle; the word occupies WIDTH cycles plus one done cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles with d_valid=1 and en=1 → d_ready=0, sdo=0, sframe=0, done=0; release reset → d_ready=1 in the next cycle.
- Single word, defaults: d=8'hA5 accepted at edge t → sdo follows 1,0,1,0,0,1,0,1 with each bit held 4 cycles; sframe high for 32 cycles; done=1 exactly at cycle t+33.
- Back-to-back: d_valid held high with 8'hFF then 8'h00 presented on consecutive handshakes → second accept happens in the done cycle; sframe low for exactly 1 cycle between the words; 0x00 is serialized correctly.
- Stall: en=0 for 5 cycles in the middle of bit 3 of 8'h3C → sdo and sframe hold; bit 3 lasts 9 cycles; done is delayed by 5 cycles; d_ready=0 throughout the stall.
- Reset mid-word: reset=0 for one cycle during bit 5 → the next cycle shows sframe=0, sdo=0, d_ready=1; done never pulses for the abandoned word.
- Parameter variant WIDTH=8, DIV=1, MSB_FIRST=0: d=8'h01 → sdo=1 for one cycle, then 0 for 7 cycles; done at t+9; d changing during SHIFT has no effect.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load and framed serial output
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sdo,
    output logic             sframe,
    output logic             done
);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sdo_q, sdo_d;
    logic             sframe_q, sframe_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shift_next;
    logic             next_bit;

    assign d_ready = reset & en & (state_q == IDLE);
    assign sdo     = sdo_q;
    assign sframe  = sframe_q;
    assign done    = done_q;

    // en low freezes every register, which also stretches the current bit period
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            sdo_q    <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            sdo_q    <= sdo_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        div_d      = div_q;
        sdo_d      = sdo_q;
        sframe_d   = sframe_q;
        done_d     = 1'b0;
        shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        next_bit   = MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];
        case (state_q)
            IDLE: begin
                sdo_d    = 1'b0;
                sframe_d = 1'b0;
                if (d_valid && d_ready) begin
                    // first bit goes out on sdo in the cycle right after the load edge
                    state_d  = SHIFT;
                    shift_d  = d;
                    bit_d    = '0;
                    div_d    = '0;
                    sdo_d    = MSB_FIRST ? d[WIDTH-1] : d[0];
                    sframe_d = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d  = IDLE;
                        bit_d    = '0;
                        shift_d  = '0;
                        sdo_d    = 1'b0;
                        sframe_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_next;
                        sdo_d   = next_bit;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (DIV=4 MSB-first and DIV=1 LSB-first)
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic       d_valid = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_ready0, sdo0, sframe0, done0;
    logic       d_ready1, sdo1, sframe1, done1;

    int checks = 0;
    int errors = 0;

    int         busy [2];
    bit         acc [2];
    int         words_done [2];
    bit         active [2];
    int         pos [2];
    logic [7:0] cur [2];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    logic       pr = 1'b0;
    logic       pe = 1'b0;
    bit         mon_on = 1'b0;

    piso_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset_n), .en(en), .d(d), .d_valid(d_valid),
        .d_ready(d_ready0), .sdo(sdo0), .sframe(sframe0), .done(done0)
    );

    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset_n), .en(en), .d(d), .d_valid(d_valid),
        .d_ready(d_ready1), .sdo(sdo1), .sframe(sframe1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word occupies 8*DIV enabled cycles, then one done cycle; bit k sits in cycles k*DIV..(k+1)*DIV-1
    task automatic mon(input int i, input logic so, input logic sf, input logic dn);
        int         dv;
        int         k;
        int         sz;
        logic       eb;
        logic [7:0] w;
        dv = div_of(i);
        if (!pr) begin
            active[i] = 1'b0;
            chk({so, sf, dn} === 3'b000, $sformatf("dut%0d_reset_outputs", i), {so, sf, dn}, 0);
            return;
        end
        if (active[i] && pe) begin
            pos[i]++;
            if (pos[i] > 8 * dv) begin
                active[i] = 1'b0;
                words_done[i]++;
            end
        end
        if (!active[i] && sf === 1'b1) begin
            sz = (i == 0) ? sb0.size() : sb1.size();
            chk(sz != 0, $sformatf("dut%0d_unexpected_frame", i), sz, 1);
            if (sz != 0) begin
                w = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                cur[i]    = w;
                active[i] = 1'b1;
                pos[i]    = 0;
            end
        end
        if (!active[i]) begin
            chk({so, sf, dn} === 3'b000, $sformatf("dut%0d_idle_outputs", i), {so, sf, dn}, 0);
        end else if (pos[i] < 8 * dv) begin
            k  = pos[i] / dv;
            eb = cur[i][(i == 0) ? 7 - k : k];
            chk({so, sf, dn} === {eb, 1'b1, 1'b0},
                $sformatf("dut%0d_bit%0d_word%0h", i, k, cur[i]), {so, sf, dn}, {eb, 2'b10});
        end else begin
            chk({so, sf, dn} === 3'b001, $sformatf("dut%0d_done_cycle", i), {so, sf, dn}, 3'b001);
        end
    endtask

    always @(posedge clk) begin
        pr     <= reset_n;
        pe     <= en;
        mon_on <= 1'b1;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, sdo0, sframe0, done0);
            mon(1, sdo1, sframe1, done1);
        end
    end

    task automatic step(input logic r, input logic e, input logic v, input logic [7:0] w);
        logic er [2];
        @(negedge clk);
        reset_n = r;
        en      = e;
        d_valid = v;
        d       = w;
        #1;
        for (int i = 0; i < 2; i++) er[i] = r && e && (busy[i] == 0);
        chk(d_ready0 === er[0], "dut0_d_ready", d_ready0, er[0]);
        chk(d_ready1 === er[1], "dut1_d_ready", d_ready1, er[1]);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b0;
            if (!r) begin
                busy[i] = 0;
            end else if (e) begin
                if (v && er[i]) begin
                    if (i == 0) sb0.push_back(w);
                    else        sb1.push_back(w);
                    busy[i] = 8 * div_of(i);
                    acc[i]  = 1'b1;
                end else if (busy[i] > 0) begin
                    busy[i]--;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    endtask

    task automatic send0(input logic [7:0] w);
        int n;
        n = 0;
        acc[0] = 1'b0;
        while (!acc[0] && n < 100) begin
            step(1'b1, 1'b1, 1'b1, w);
            n++;
        end
        chk(acc[0], "dut0_accept_timeout", n, 100);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy[i] = 0; acc[i] = 1'b0; words_done[i] = 0; active[i] = 1'b0; pos[i] = 0; cur[i] = 8'h00;
        end
        // Reset held with d_valid high
        repeat (3) step(1'b0, 1'b1, 1'b1, 8'hA5);
        idle(2);
        // Single word
        send0(8'hA5);
        idle(40);
        // Back-to-back with d_valid held
        send0(8'hFF);
        send0(8'h00);
        idle(40);
        // Stall inside bit 3
        send0(8'h3C);
        idle(13);
        repeat (5) step(1'b1, 1'b0, 1'b0, 8'($urandom));
        idle(40);
        // Reset during bit 5
        send0(8'h96);
        idle(22);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        idle(10);
        // Short word for the DIV=1 LSB-first instance; d wiggles while it shifts
        send0(8'h01);
        for (int j = 0; j < 40; j++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
        // Random traffic
        for (int j = 0; j < 3000; j++) begin
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 1) != 0), 8'($urandom));
        end
        idle(50);
        @(negedge clk);
        chk(sb0.size() == 0, "dut0_scoreboard_drained", sb0.size(), 0);
        chk(sb1.size() == 0, "dut1_scoreboard_drained", sb1.size(), 0);
        chk(words_done[0] >= 20, "dut0_words_completed", words_done[0], 20);
        chk(words_done[1] >= 60, "dut1_words_completed", words_done[1], 60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
